sms4_lin_xform: RTL
===================

# sms4_lin_xform

Pipelined, parametrised SMS4 linear-transform unit with a valid/ready handshake. It computes either the round transform L (encryption datapath) or the key-schedule transform L' on one word per cycle, with the transform selected per word. It sits between the S-box layer (τ) and the round XOR, and is shared by the round-function and key-expansion paths.

## Interface
- BWIDTH, 32, word width; bit 0 is the MSB, ports declared [0:BWIDTH-1]
- ROT_E1, 2, first rotate amount for L
- ROT_E2, 10, second rotate amount for L
- ROT_E3, 18, third rotate amount for L
- ROT_E4, 24, fourth rotate amount for L
- ROT_K1, 13, first rotate amount for L'
- ROT_K2, 23, second rotate amount for L'
- clk  in  1  clock; all state is updated on the rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input word present
- in_ready  out  1  unit accepts the input word this cycle
- in_mode  in  1  transform select: 0 = L, 1 = L'
- in_data  in  BWIDTH  word B
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts the result
- out_mode  out  1  mode that travelled with the word
- out_data  out  BWIDTH  transform result

## Operation
- Rotate-left moves bits toward index 0: rotl(B,n)[i] = B[(i+n) mod BWIDTH].
- Rotate amounts are taken mod BWIDTH, so any value is legal.
- Transforms:
  - L = B ^ rotl(B,E1) ^ rotl(B,E2) ^ rotl(B,E3) ^ rotl(B,E4).
  - L' = B ^ rotl(B,K1) ^ rotl(B,K2).
- Transfer rules:
  - An input transfers when in_valid && in_ready.
  - An output transfers when out_valid && out_ready.
- Each stage holds a valid bit, a mode bit and data; stages form an elastic pipeline.
- A stage loads when it is empty or when its contents move on in the same cycle.
- Stall: out_valid && !out_ready freezes the output stage. Upstream stages keep filling until the whole pipeline is full.
- in_ready = !stage0_valid || stage0_advances. It is combinational from out_ready; there is no combinational path from in_valid.
- Order is strictly preserved. Modes may alternate word-to-word with no bubble.
- out_data, out_mode and out_valid hold stable while out_valid && !out_ready.
- Reset (asynchronous, any cycle, including mid-stream) clears:
  - all valid bits to 0;
  - data to 0;
  - mode to 0.
  In-flight words are dropped.
- Reset values: in_ready = 1, out_valid = 0, out_mode = 0, out_data = 0.

## Timing
- With SMS4_LT_PIPE2_EN: latency 2 cycles from the input transfer edge to out_valid.
- Without SMS4_LT_PIPE2_EN: latency 1 cycle.
- Throughput is 1 word/cycle when out_ready = 1.
- Simultaneous input and output transfer on a full pipeline: both occur and occupancy is unchanged.
- out_ready low for N cycles with a full pipeline: in_ready is low for N cycles and no word is lost.
- First cycle after reset deasserts: in_ready = 1.

## Configuration
- SMS4_LT_PIPE2_EN defined:
  - Two register stages.
  - Stage 0 registers B and a partial XOR: B^rotl(E1)^rotl(E2) for L, or B^rotl(K1) for L'.
  - Stage 1 XORs in the remaining rotations: E3 and E4, or K2.
  - Capacity is 2 words.
- Undefined:
  - A single register stage computes the full transform.
  - Capacity is 1 word.
  - The in_ready rule above applies to that single stage.

## Structure
- The shared package sms4_pkg holds:
  - the default rotate constants (2, 10, 18, 24, 13, 23);
  - the mode encoding constants SMS4_MODE_ENC = 0 and SMS4_MODE_KEY = 1.
- Sub-module sms4_rotl is a combinational rotate-left with parameters BWIDTH and ROT. Instantiate it six times, once per rotate amount.

## Test plan
- Mode 0, B=0x00000001, out_ready=1 -> out_data=0x01040405, out_mode=0, after the configured latency.
- Mode 1, B=0x00000001 -> 0x00802001. Mode 1, B=0x80000000 -> 0x80401000.
- Back-to-back words alternating mode 0/1, B=0x80000000 each -> outputs in order: 0x80820202, 0x80401000, 0x80820202, ... with no bubbles.
- Hold out_ready=0 for 5 cycles while in_valid=1 -> in_ready drops once capacity is reached (1 or 2 words), out_data is stable, and on release all words emerge in order with none duplicated.
- Assert rst for 1 cycle with 2 words in flight -> out_valid=0 and in_ready=1 immediately; the dropped words never appear.
- Random stimulus against a reference model for 10k words with random out_ready -> zero mismatches, in both macro configurations.

Source files
------------

// File: rtl/sms4_pkg.sv
// Shared SMS4 constants: default rotate amounts for L and L', and the mode encoding
// carried alongside each word.
package sms4_pkg;

   localparam int unsigned SMS4_ROT_E1 = 2;
   localparam int unsigned SMS4_ROT_E2 = 10;
   localparam int unsigned SMS4_ROT_E3 = 18;
   localparam int unsigned SMS4_ROT_E4 = 24;
   localparam int unsigned SMS4_ROT_K1 = 13;
   localparam int unsigned SMS4_ROT_K2 = 23;

   localparam logic SMS4_MODE_ENC = 1'b0;
   localparam logic SMS4_MODE_KEY = 1'b1;

endpackage

// File: rtl/sms4_rotl.sv
// Combinational rotate-left on an MSB-first bus: bit i takes bit (i+ROT) mod BWIDTH.
module sms4_rotl #(
   parameter int unsigned BWIDTH = 32,
   parameter int unsigned ROT    = 0
) (
   input  logic [0:BWIDTH-1] data_i,
   output logic [0:BWIDTH-1] data_o
);

   for (genvar i = 0; i < BWIDTH; i++) begin : g_bit
      localparam int unsigned Src = (i + (ROT % BWIDTH)) % BWIDTH;
      assign data_o[i] = data_i[Src];
   end

endmodule

// File: rtl/sms4_lin_xform.sv
// SMS4 linear transform (L or L', chosen per word) as an elastic valid/ready pipeline.
// Define SMS4_LT_PIPE2_EN for two register stages; otherwise a single stage is built.
module sms4_lin_xform
   import sms4_pkg::*;
#(
   parameter int unsigned BWIDTH = 32,
   parameter int unsigned ROT_E1 = SMS4_ROT_E1,
   parameter int unsigned ROT_E2 = SMS4_ROT_E2,
   parameter int unsigned ROT_E3 = SMS4_ROT_E3,
   parameter int unsigned ROT_E4 = SMS4_ROT_E4,
   parameter int unsigned ROT_K1 = SMS4_ROT_K1,
   parameter int unsigned ROT_K2 = SMS4_ROT_K2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_mode,
   input  logic [0:BWIDTH-1] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_mode,
   output logic [0:BWIDTH-1] out_data
);

   logic [0:BWIDTH-1] late_src;
   logic [0:BWIDTH-1] rot_e1, rot_e2, rot_e3, rot_e4, rot_k1, rot_k2;

   // E1, E2, K1 always act on the incoming word; E3, E4, K2 act on late_src.
   sms4_rotl #(.BWIDTH(BWIDTH), .ROT(ROT_E1)) u_rot_e1 (.data_i(in_data),  .data_o(rot_e1));
   sms4_rotl #(.BWIDTH(BWIDTH), .ROT(ROT_E2)) u_rot_e2 (.data_i(in_data),  .data_o(rot_e2));
   sms4_rotl #(.BWIDTH(BWIDTH), .ROT(ROT_K1)) u_rot_k1 (.data_i(in_data),  .data_o(rot_k1));
   sms4_rotl #(.BWIDTH(BWIDTH), .ROT(ROT_E3)) u_rot_e3 (.data_i(late_src), .data_o(rot_e3));
   sms4_rotl #(.BWIDTH(BWIDTH), .ROT(ROT_E4)) u_rot_e4 (.data_i(late_src), .data_o(rot_e4));
   sms4_rotl #(.BWIDTH(BWIDTH), .ROT(ROT_K2)) u_rot_k2 (.data_i(late_src), .data_o(rot_k2));

`ifdef SMS4_LT_PIPE2_EN
   logic              v0_q, v0_d, m0_q, m0_d;
   logic [0:BWIDTH-1] b0_q, b0_d, p0_q, p0_d;
   logic              v1_q, v1_d, m1_q, m1_d;
   logic [0:BWIDTH-1] d1_q, d1_d;
   logic              s1_load;

   assign late_src = b0_q;

   always_comb begin
      v0_d     = v0_q;
      m0_d     = m0_q;
      b0_d     = b0_q;
      p0_d     = p0_q;
      v1_d     = v1_q;
      m1_d     = m1_q;
      d1_d     = d1_q;
      s1_load  = !v1_q || out_ready;
      in_ready = !v0_q || s1_load;
      if (in_ready) begin
         v0_d = in_valid;
         if (in_valid) begin
            m0_d = in_mode;
            b0_d = in_data;
            p0_d = (in_mode == SMS4_MODE_KEY) ? (in_data ^ rot_k1)
                                              : (in_data ^ rot_e1 ^ rot_e2);
         end
      end
      if (s1_load) begin
         v1_d = v0_q;
         if (v0_q) begin
            m1_d = m0_q;
            d1_d = (m0_q == SMS4_MODE_KEY) ? (p0_q ^ rot_k2) : (p0_q ^ rot_e3 ^ rot_e4);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v0_q <= 1'b0;
         m0_q <= SMS4_MODE_ENC;
         b0_q <= '0;
         p0_q <= '0;
         v1_q <= 1'b0;
         m1_q <= SMS4_MODE_ENC;
         d1_q <= '0;
      end else begin
         v0_q <= v0_d;
         m0_q <= m0_d;
         b0_q <= b0_d;
         p0_q <= p0_d;
         v1_q <= v1_d;
         m1_q <= m1_d;
         d1_q <= d1_d;
      end
   end

   assign out_valid = v1_q;
   assign out_mode  = m1_q;
   assign out_data  = d1_q;
`else
   logic              v_q, v_d, m_q, m_d;
   logic [0:BWIDTH-1] d_q, d_d;

   assign late_src = in_data;

   always_comb begin
      v_d      = v_q;
      m_d      = m_q;
      d_d      = d_q;
      in_ready = !v_q || out_ready;
      if (in_ready) begin
         v_d = in_valid;
         if (in_valid) begin
            m_d = in_mode;
            d_d = (in_mode == SMS4_MODE_KEY) ? (in_data ^ rot_k1 ^ rot_k2)
                                             : (in_data ^ rot_e1 ^ rot_e2 ^ rot_e3 ^ rot_e4);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q <= 1'b0;
         m_q <= SMS4_MODE_ENC;
         d_q <= '0;
      end else begin
         v_q <= v_d;
         m_q <= m_d;
         d_q <= d_d;
      end
   end

   assign out_valid = v_q;
   assign out_mode  = m_q;
   assign out_data  = d_q;
`endif

endmodule
